instr_fetch_unit: RTL and testbench

- Front end of the BRISC core. Fetches 3-byte instructions from byte-wide instruction memory (1-cycle read latency) and assembles them.
- Decodes each instruction into the operand-select fields consumed downstream: imm_ctl, immediate, instr_pc, and register indices.
- Presents the result to the execute stage over a valid/ready handshake.
- Handles taken branches and jumps via a redirect input, and handles HALT.

---
 rtl/brisc_pkg.sv | 24 ++
 rtl/instr_fetch_unit_decode.sv | 27 ++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared BRISC front-end constants: operand-select codes, opcode classes and fetch states.
// Used by the fetch unit, its decoder and the downstream operand mux / control unit.
package brisc_pkg;

  localparam logic [1:0] IMM_REG = 2'd0;
  localparam logic [1:0] IMM_IMM = 2'd1;
  localparam logic [1:0] IMM_PC  = 2'd2;

  // opcode[7:6] instruction classes
  localparam logic [1:0] OPC_ALU_RR = 2'b00;
  localparam logic [1:0] OPC_ALU_RI = 2'b01;
  localparam logic [1:0] OPC_JAL    = 2'b10;
  localparam logic [1:0] OPC_SYS    = 2'b11;

  typedef enum logic [2:0] {
    ST_F0    = 3'd0,
    ST_F1    = 3'd1,
    ST_F2    = 3'd2,
    ST_F3    = 3'd3,
    ST_ISSUE = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_decode.sv
// Opcode decoder: operand-select class, ALU op and HALT detect. Purely combinational.
module instr_decode
  import brisc_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic [7:0] opcode,
  output logic [1:0] imm_ctl,
  output logic [3:0] alu_op,
  output logic       is_halt
);

  always_comb begin
    imm_ctl = IMM_REG;
    unique case (opcode[7:6])
      OPC_ALU_RR: imm_ctl = IMM_REG;
      OPC_ALU_RI: imm_ctl = IMM_IMM;
      OPC_JAL:    imm_ctl = IMM_PC;
      OPC_SYS:    imm_ctl = IMM_REG;
      default:    imm_ctl = IMM_REG;
    endcase
  end

  assign alu_op  = opcode[3:0];
  assign is_halt = (opcode == HALT_OPCODE);

endmodule

// File: rtl/instr_fetch_unit.sv
// BRISC fetch: reads 3 bytes per instruction (5 cycles F0..ISSUE), decodes, issues over valid/ready.
// Decoded outputs are registered and held in ISSUE until accepted; redirect overrides everything.
module instr_fetch_unit
  import brisc_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] imem_addr,
  output logic       imem_rd_en,
  input  logic [7:0] imem_rdata,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] alu_op,
  output logic [3:0] rd,
  output logic [3:0] rs,
  output logic [7:0] immediate,
  output logic [1:0] imm_ctl,
  output logic [7:0] instr_pc,
  output logic       halted
);

  fetch_state_e state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] op_q, op_d;
  logic [7:0] b1_q, b1_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [3:0] rd_q, rd_d;
  logic [3:0] rs_q, rs_d;
  logic [7:0] imm_q, imm_d;
  logic [1:0] imm_ctl_q, imm_ctl_d;
  logic [7:0] instr_pc_q, instr_pc_d;
  logic       halt_q, halt_d;

  logic [1:0] dec_imm_ctl;
  logic [3:0] dec_alu_op;
  logic       dec_is_halt;

  instr_decode #(.HALT_OPCODE(HALT_OPCODE)) u_decode (
    .opcode  (op_q),
    .imm_ctl (dec_imm_ctl),
    .alu_op  (dec_alu_op),
    .is_halt (dec_is_halt)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    op_d       = op_q;
    b1_d       = b1_q;
    alu_op_d   = alu_op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    imm_ctl_d  = imm_ctl_q;
    instr_pc_d = instr_pc_q;
    halt_d     = halt_q;

    unique case (state_q)
      ST_F0: state_d = ST_F1;
      ST_F1: begin
        op_d    = imem_rdata;
        state_d = ST_F2;
      end
      ST_F2: begin
        b1_d    = imem_rdata;
        state_d = ST_F3;
      end
      // Byte2 arrives now; latch the whole decoded instruction at once so
      // outputs only ever change on the way into ISSUE.
      ST_F3: begin
        alu_op_d   = dec_alu_op;
        imm_ctl_d  = dec_imm_ctl;
        halt_d     = dec_is_halt;
        rd_d       = b1_q[7:4];
        rs_d       = b1_q[3:0];
        imm_d      = imem_rdata;
        instr_pc_d = pc_q;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          if (halt_q) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 8'd3;
            state_d = ST_F0;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_F0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_F0;
      pc_q       <= RESET_PC;
      op_q       <= 8'd0;
      b1_q       <= 8'd0;
      alu_op_q   <= 4'd0;
      rd_q       <= 4'd0;
      rs_q       <= 4'd0;
      imm_q      <= 8'd0;
      imm_ctl_q  <= IMM_REG;
      instr_pc_q <= 8'd0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      b1_q       <= b1_d;
      alu_op_q   <= alu_op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      imm_q      <= imm_d;
      imm_ctl_q  <= imm_ctl_d;
      instr_pc_q <= instr_pc_d;
      halt_q     <= halt_d;
    end
  end

  always_comb begin
    imem_addr = pc_q;
    unique case (state_q)
      ST_F1:   imem_addr = pc_q + 8'd1;
      ST_F2:   imem_addr = pc_q + 8'd2;
      default: imem_addr = pc_q;
    endcase
  end

  // State is already F0 during reset, so the strobe must be gated explicitly.
  assign imem_rd_en  = !reset && (state_q == ST_F0 || state_q == ST_F1 || state_q == ST_F2);
  assign instr_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALT);
  assign alu_op      = alu_op_q;
  assign rd          = rd_q;
  assign rs          = rs_q;
  assign immediate   = imm_q;
  assign imm_ctl     = imm_ctl_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle-latency byte memory model.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic [7:0] imem_addr;
  logic       imem_rd_en;
  logic [7:0] imem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [7:0] immediate;
  logic [1:0] imm_ctl;
  logic [7:0] instr_pc;
  logic       halted;

  int n_checks = 0;
  int n_fails  = 0;
  int hs_cnt   = 0;
  int hs_before;

  logic [7:0] mem [256];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .alu_op         (alu_op),
    .rd             (rd),
    .rs             (rs),
    .immediate      (immediate),
    .imm_ctl        (imm_ctl),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) hs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect_to(input logic [7:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // {alu_op, rd, rs, immediate, imm_ctl, instr_pc}
  function automatic logic [31:0] fields();
    return {2'b00, alu_op, rd, rs, immediate, imm_ctl, instr_pc};
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] a, input logic [3:0] d, input logic [3:0] s,
                                     input logic [7:0] im, input logic [1:0] ic, input logic [7:0] pc);
    return {2'b00, a, d, s, im, ic, pc};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h45; mem[8'h01] = 8'h12; mem[8'h02] = 8'h7A;
    mem[8'h03] = 8'h12; mem[8'h04] = 8'h34; mem[8'h05] = 8'hFF;
    mem[8'h06] = 8'hC1; mem[8'h07] = 8'h00;
    mem[8'h08] = 8'h61; mem[8'h09] = 8'h23; mem[8'h0A] = 8'h45;
    mem[8'h10] = 8'h83; mem[8'h11] = 8'h9C; mem[8'h12] = 8'h11;
    mem[8'h40] = 8'h2E; mem[8'h41] = 8'h56; mem[8'h42] = 8'h78;
    mem[8'hFE] = 8'h47; mem[8'hFF] = 8'hA5;
    imem_rdata     = 8'h00;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b1;

    ticks(2);
    check_eq("rst_rd_en", imem_rd_en, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_fields", fields(), 0);

    // first instruction at 0x00, ready held high
    reset = 1'b0;
    #1;
    check_eq("f0_rd_en", imem_rd_en, 1);
    check_eq("f0_addr", imem_addr, 8'h00);
    tick();
    check_eq("f1_addr", imem_addr, 8'h01);
    ticks(2);
    check_eq("c4_valid", instr_valid, 0);
    tick();
    check_eq("c5_valid", instr_valid, 1);
    check_eq("i0_fields", fields(), mk(4'h5, 4'h1, 4'h2, 8'h7A, 2'd1, 8'h00));
    check_eq("issue_rd_en", imem_rd_en, 0);
    tick();
    check_eq("i0_next_addr", imem_addr, 8'h03);
    check_eq("i0_next_valid", instr_valid, 0);

    // stall in ISSUE for 7 cycles
    instr_ready = 1'b0;
    ticks(4);
    check_eq("i1_valid", instr_valid, 1);
    check_eq("i1_fields", fields(), mk(4'h2, 4'h3, 4'h4, 8'hFF, 2'd0, 8'h03));
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("stall_valid", instr_valid, 1);
      check_eq("stall_rd_en", imem_rd_en, 0);
      check_eq("stall_fields", fields(), mk(4'h2, 4'h3, 4'h4, 8'hFF, 2'd0, 8'h03));
    end
    instr_ready = 1'b1;
    tick();
    check_eq("stall_next_addr", imem_addr, 8'h06);

    // redirect to 0x40 while in F2 of the instruction at 0x06
    ticks(2);
    check_eq("f2_addr", imem_addr, 8'h08);
    redirect_to(8'h40);
    check_eq("redir_valid", instr_valid, 0);
    check_eq("redir_addr", imem_addr, 8'h40);
    check_eq("redir_rd_en", imem_rd_en, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("redir_no_valid", instr_valid, 0);
    end
    tick();
    check_eq("i40_valid", instr_valid, 1);
    check_eq("i40_fields", fields(), mk(4'hE, 4'h5, 4'h6, 8'h78, 2'd0, 8'h40));
    tick();
    check_eq("i40_next_addr", imem_addr, 8'h43);

    // jump-and-link at 0x10 (redirect taken in F0)
    redirect_to(8'h10);
    check_eq("f0_redir_addr", imem_addr, 8'h10);
    ticks(4);
    check_eq("jal_valid", instr_valid, 1);
    check_eq("jal_fields", fields(), mk(4'h3, 4'h9, 4'hC, 8'h11, 2'd2, 8'h10));
    check_eq("jal_link", 8'(instr_pc + 8'd3), 8'h13);
    tick();
    check_eq("jal_next_addr", imem_addr, 8'h13);

    // redirect to 0x20 coinciding with the handshake at 0x08
    redirect_to(8'h08);
    ticks(4);
    check_eq("i08_valid", instr_valid, 1);
    check_eq("i08_fields", fields(), mk(4'h1, 4'h2, 4'h3, 8'h45, 2'd1, 8'h08));
    hs_before = hs_cnt;
    redirect_to(8'h20);
    check_eq("hs_redir_valid", instr_valid, 0);
    check_eq("hs_redir_addr", imem_addr, 8'h20);
    check_eq("hs_single", hs_cnt, hs_before + 1);

    // wraparound fetch at 0xFE (redirect taken in F1)
    tick();
    redirect_to(8'hFE);
    check_eq("wrap_a0", imem_addr, 8'hFE);
    tick();
    check_eq("wrap_a1", imem_addr, 8'hFF);
    tick();
    check_eq("wrap_a2", imem_addr, 8'h00);
    ticks(2);
    check_eq("wrap_valid", instr_valid, 1);
    check_eq("wrap_fields", fields(), mk(4'h7, 4'hA, 4'h5, 8'h45, 2'd1, 8'hFE));
    tick();
    check_eq("wrap_next_pc", imem_addr, 8'h01);

    // HALT at 0x05
    redirect_to(8'h05);
    ticks(4);
    check_eq("halt_issue_valid", instr_valid, 1);
    check_eq("halt_fields", fields(), mk(4'hF, 4'hC, 4'h1, 8'h00, 2'd0, 8'h05));
    check_eq("halt_pre", halted, 0);
    tick();
    check_eq("halted", halted, 1);
    check_eq("halted_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("halted_hold", halted, 1);
      check_eq("halted_rd_en", imem_rd_en, 0);
    end
    redirect_to(8'h05);
    check_eq("unhalt", halted, 0);
    check_eq("unhalt_addr", imem_addr, 8'h05);
    check_eq("unhalt_rd_en", imem_rd_en, 1);
    ticks(5);
    check_eq("rehalted", halted, 1);

    // asynchronous reset while halted
    reset = 1'b1;
    #1;
    check_eq("arst_halted", halted, 0);
    check_eq("arst_valid", instr_valid, 0);
    check_eq("arst_rd_en", imem_rd_en, 0);
    check_eq("arst_fields", fields(), 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("rel_addr", imem_addr, 8'h00);
    check_eq("rel_rd_en", imem_rd_en, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
